// File: rtl/hazard_detect_id.sv
// ID-stage hazard detector: tracks issued writers in an EXE/MEM/WB shadow pipeline and stalls ID
// when a live source cannot be forwarded. Optional macro FORWARDING_EN selects the load-use-only build.
module hazard_detect_id #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_ID,
    input  logic [REG_W-1:0] src1_ID,
    input  logic [REG_W-1:0] src2_ID,
    input  logic [REG_W-1:0] ST_src_ID,
    input  logic             use_src2_ID,
    input  logic             use_ST_ID,
    input  logic [REG_W-1:0] dest_ID,
    input  logic             WB_EN_ID,
    input  logic             MEM_R_EN_ID,
    input  logic             flush,
    output logic             hazard_stall,
    output logic [15:0]      pending_mask,
    output logic [CNT_W-1:0] stall_cnt
);

    // Only the EXE entry needs the load flag; MEM/WB entries just describe the writer.
    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] dest;
        logic             wb;
        logic             mr;
    } x_entry_t;

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] dest;
        logic             wb;
    } writer_t;

    x_entry_t x_q;
    writer_t  m_q;
    writer_t  w_q;

    logic [2:0] src_live;
    logic [2:0] hit_x;
    logic [2:0] src_blocked;
    logic       any_blocked;
    logic       issue;

    // Per-source comparison against the in-flight writers.
    always_comb begin
        src_live = {use_ST_ID, use_src2_ID, 1'b1};
        hit_x[0] = x_q.v & x_q.wb & (x_q.dest == src1_ID);
        hit_x[1] = x_q.v & x_q.wb & (x_q.dest == src2_ID);
        hit_x[2] = x_q.v & x_q.wb & (x_q.dest == ST_src_ID);
    end

`ifdef FORWARDING_EN
    // ALU results forward from EXE/MEM, so only a load still in EXE blocks its consumer.
    always_comb begin
        src_blocked = hit_x & {3{x_q.mr}};
    end
`else
    logic [2:0] hit_m;
    logic       unused_x_mr;

    // Without forwarding every RAW dependency on EXE or MEM must wait for writeback.
    always_comb begin
        hit_m[0]    = m_q.v & m_q.wb & (m_q.dest == src1_ID);
        hit_m[1]    = m_q.v & m_q.wb & (m_q.dest == src2_ID);
        hit_m[2]    = m_q.v & m_q.wb & (m_q.dest == ST_src_ID);
        src_blocked = hit_x | hit_m;
    end

    assign unused_x_mr = x_q.mr;
`endif

    always_comb begin
        any_blocked  = |(src_blocked & src_live);
        hazard_stall = valid_ID & ~flush & any_blocked;
        issue        = valid_ID & ~flush & ~any_blocked;
    end

    // WB is tracked only so the pending mask covers writers until the register file commits.
    always_comb begin
        pending_mask = '0;
        if (x_q.v && x_q.wb) pending_mask[x_q.dest] = 1'b1;
        if (m_q.v && m_q.wb) pending_mask[m_q.dest] = 1'b1;
        if (w_q.v && w_q.wb) pending_mask[w_q.dest] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q       <= '0;
            m_q       <= '0;
            w_q       <= '0;
            stall_cnt <= '0;
        end else begin
            w_q <= m_q;
            m_q <= '{v: x_q.v, dest: x_q.dest, wb: x_q.wb};
            if (issue) begin
                x_q <= '{v: 1'b1, dest: dest_ID, wb: WB_EN_ID, mr: MEM_R_EN_ID};
            end else begin
                x_q <= '0;
            end
            if (hazard_stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule
